// File: rtl/sum_threshold_detector_pkg.sv
// rtl/sum_threshold_detector_pkg.sv - state encodings and sizing helper for the sum threshold detector
package sum_threshold_detector_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUAL  = 2'd1,
        S_ALARM = 2'd2,
        S_HOLD  = 2'd3
    } det_state_t;

    // Counter width that can hold values 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sum_threshold_detector_sat_counter.sv
// rtl/sum_threshold_detector_sat_counter.sv - up counter that saturates at all-ones (module sat_counter)
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/sum_threshold_detector.sv
// rtl/sum_threshold_detector.sv - debounced high-sum alarm with hysteresis, hold-off and event count
// Optional peak tracking is built only when PEAK_TRACK_EN is defined.
module sum_threshold_detector
    import sum_threshold_detector_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] HI_THRESH = 8'd192,
    parameter logic [WIDTH-1:0] LO_THRESH = 8'd64,
    parameter int               CONFIRM   = 3,
    parameter int               HOLD      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sum,
    output logic             alarm,
    output logic             alarm_rise,
    output logic [7:0]       alarm_count,
    output logic [WIDTH-1:0] peak
);

    localparam int QW = cnt_width(CONFIRM - 1);
    localparam int HW = cnt_width(HOLD);
    localparam logic [QW-1:0] Q_LAST = QW'(CONFIRM - 1);
    localparam logic [HW-1:0] H_LAST = HW'(HOLD);

    det_state_t    state, state_next;
    logic [QW-1:0] qcnt, qcnt_next;
    logic [HW-1:0] hcnt, hcnt_next;
    logic          rise_next;
    logic          is_high, is_low;

    assign is_high = (sum >= HI_THRESH);
    assign is_low  = (sum <= LO_THRESH);

    always_comb begin
        state_next = state;
        qcnt_next  = qcnt;
        hcnt_next  = hcnt;
        rise_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (is_high) begin
                    if (CONFIRM == 1) begin
                        state_next = S_ALARM;
                        rise_next  = 1'b1;
                    end else begin
                        state_next = S_QUAL;
                        qcnt_next  = QW'(1);
                    end
                end
            end
            S_QUAL: begin
                if (!is_high) begin
                    state_next = S_IDLE;
                    qcnt_next  = '0;
                end else if (qcnt == Q_LAST) begin
                    state_next = S_ALARM;
                    qcnt_next  = '0;
                    rise_next  = 1'b1;
                end else begin
                    qcnt_next = qcnt + 1'b1;
                end
            end
            S_ALARM: begin
                if (is_low) begin
                    if (HOLD == 0) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_HOLD;
                        hcnt_next  = HW'(1);
                    end
                end
            end
            S_HOLD: begin
                // A high sample re-arms directly; it is a continuation, not a new event.
                if (is_high) begin
                    state_next = S_ALARM;
                    hcnt_next  = '0;
                end else if (hcnt == H_LAST) begin
                    state_next = S_IDLE;
                    hcnt_next  = '0;
                end else begin
                    hcnt_next = hcnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            qcnt       <= '0;
            hcnt       <= '0;
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
        end else begin
            state      <= state_next;
            qcnt       <= qcnt_next;
            hcnt       <= hcnt_next;
            alarm      <= (state_next == S_ALARM) || (state_next == S_HOLD);
            alarm_rise <= rise_next;
        end
    end

    sat_counter #(
        .WIDTH (8)
    ) u_alarm_count (
        .clk   (clk),
        .reset (reset),
        .inc   (rise_next),
        .count (alarm_count)
    );

`ifdef PEAK_TRACK_EN
    logic [WIDTH-1:0] peak_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q <= '0;
        end else if (sum > peak_q) begin
            peak_q <= sum;
        end
    end

    assign peak = peak_q;
`else
    assign peak = '0;
`endif

endmodule

// File: tb/tb_sum_threshold_detector.sv
// tb/tb_sum_threshold_detector.sv - directed vector bench for sum_threshold_detector
module tb_sum_threshold_detector;

    typedef struct {
        logic [7:0] sum;
        logic       alarm;
        logic       rise;
        logic [7:0] count;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] sum;
    logic       alarm;
    logic       alarm_rise;
    logic [7:0] alarm_count;
    logic [7:0] peak;

    int checks;
    int failures;
    vec_t vecs[$];

    sum_threshold_detector dut (
        .clk         (clk),
        .reset       (reset),
        .sum         (sum),
        .alarm       (alarm),
        .alarm_rise  (alarm_rise),
        .alarm_count (alarm_count),
        .peak        (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input int s, input int a, input int r, input int c);
        vec_t v;
        v.sum = 8'(s); v.alarm = 1'(a); v.rise = 1'(r); v.count = 8'(c);
        vecs.push_back(v);
    endtask

    // Drive sum away from the edge, then sample outputs just after the capturing edge.
    task automatic step(input int s);
        @(negedge clk);
        sum = 8'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int exp_cnt;
        checks   = 0;
        failures = 0;
        sum      = '0;
        reset    = 1'b1;
        #2;
        check("reset_alarm", alarm, 0);
        check("reset_rise", alarm_rise, 0);
        check("reset_count", alarm_count, 0);
        check("reset_peak", peak, 0);
        do_reset();

        for (int i = 0; i < 10; i++) add(0, 0, 0, 0);
        add(200, 0, 0, 0); add(200, 0, 0, 0); add(100, 0, 0, 0);
        add(200, 0, 0, 0); add(200, 0, 0, 0); add(200, 1, 1, 1);
        add(100, 1, 0, 1);
        add(50, 1, 0, 1); add(50, 1, 0, 1); add(50, 1, 0, 1); add(50, 1, 0, 1);
        add(50, 0, 0, 1);
        add(200, 0, 0, 1); add(200, 0, 0, 1); add(200, 1, 1, 2);
        add(50, 1, 0, 2); add(255, 1, 0, 2);
        add(0, 1, 0, 2); add(0, 1, 0, 2); add(0, 1, 0, 2); add(0, 1, 0, 2);
        add(0, 0, 0, 2);

        foreach (vecs[i]) begin
            step(vecs[i].sum);
            check($sformatf("vec%0d_alarm", i), alarm, vecs[i].alarm);
            check($sformatf("vec%0d_rise", i), alarm_rise, vecs[i].rise);
            check($sformatf("vec%0d_count", i), alarm_count, vecs[i].count);
        end

        exp_cnt = 2;
        for (int k = 0; k < 300; k++) begin
            step(200); step(200); step(200);
            exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
            check($sformatf("sat%0d_rise", k), alarm_rise, 1);
            check($sformatf("sat%0d_count", k), alarm_count, exp_cnt);
            for (int j = 0; j < 5; j++) step(0);
            check($sformatf("sat%0d_alarm_off", k), alarm, 0);
        end
        check("sat_final", alarm_count, 255);

        step(200); step(200); step(200); step(100);
        check("mid_alarm_pre", alarm, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_reset_alarm", alarm, 0);
        check("mid_reset_count", alarm_count, 0);
        check("mid_reset_rise", alarm_rise, 0);
        @(negedge clk);
        reset = 1'b0;

        step(10); step(250); step(30);
`ifdef PEAK_TRACK_EN
        check("peak", peak, 250);
`else
        check("peak", peak, 0);
`endif
        check("post_reset_alarm", alarm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
